// File: rtl/frame_buffer_writer.sv
// Turns a row-major pixel stream into registered frame-buffer writes and issues a swap pulse at vblank.
// Write outputs lag an accept by 1 cycle; swap_buffers lags frame_sync by 1 cycle. Renderer is stalled (pixel_ready=0) from frame end until the swap cycle completes.
module frame_buffer_writer #(
    parameter int WIDTH          = 12,
    parameter int DISPLAY_WIDTH  = 4,
    parameter int DISPLAY_HEIGHT = 2,
    parameter int ADDR_LEN       = (DISPLAY_WIDTH * DISPLAY_HEIGHT > 1) ?
                                   $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pixel_valid,
    input  logic [WIDTH-1:0]    pixel_color,
    input  logic                pixel_sof,
    output logic                pixel_ready,
    input  logic                frame_sync,
    output logic                write_enable,
    output logic [ADDR_LEN-1:0] write_addr,
    output logic [WIDTH-1:0]    write_data,
    output logic                swap_buffers,
    output logic [15:0]         frame_count,
    output logic                sof_error
);
    localparam int DEPTH = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(DEPTH - 1);

    typedef enum logic [1:0] {
        WRITING,
        FRAME_DONE,
        SWAP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                write_enable_q, write_enable_d;
    logic [ADDR_LEN-1:0] write_addr_q, write_addr_d;
    logic [WIDTH-1:0]    write_data_q, write_data_d;
    logic                swap_buffers_q, swap_buffers_d;
    logic [15:0]         frame_count_q, frame_count_d;
    logic                sof_error_q, sof_error_d;
    logic                accept;

    assign pixel_ready = (state_q == WRITING);
    assign accept      = pixel_valid && pixel_ready;

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        swap_buffers_d = 1'b0;
        frame_count_d  = frame_count_q;
        sof_error_d    = sof_error_q;

        case (state_q)
            WRITING: begin
                if (accept) begin
                    write_enable_d = 1'b1;
                    write_data_d   = pixel_color;
                    // A misplaced start-of-frame resyncs the frame to address 0.
                    if (pixel_sof && (addr_q != '0)) begin
                        sof_error_d  = 1'b1;
                        write_addr_d = '0;
                        addr_d       = ADDR_LEN'(1);
                    end else begin
                        write_addr_d = addr_q;
                        if (addr_q == LAST_ADDR) begin
                            addr_d  = '0;
                            state_d = FRAME_DONE;
                        end else begin
                            addr_d = addr_q + ADDR_LEN'(1);
                        end
                    end
                end
            end
            FRAME_DONE: begin
                if (frame_sync) begin
                    state_d        = SWAP;
                    swap_buffers_d = 1'b1;
                    frame_count_d  = frame_count_q + 16'd1;
                end
            end
            SWAP: begin
                state_d = WRITING;
            end
            default: begin
                state_d = WRITING;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WRITING;
            addr_q         <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            swap_buffers_q <= 1'b0;
            frame_count_q  <= '0;
            sof_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            swap_buffers_q <= swap_buffers_d;
            frame_count_q  <= frame_count_d;
            sof_error_q    <= sof_error_d;
        end
    end

    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign swap_buffers = swap_buffers_q;
    assign frame_count  = frame_count_q;
    assign sof_error    = sof_error_q;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: per-cycle comparison against a pixel/frame model plus literal spot checks.
module tb_frame_buffer_writer;
    localparam int W     = 12;
    localparam int DW    = 4;
    localparam int DH    = 2;
    localparam int AL    = 3;
    localparam int DEPTH = DW * DH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pixel_valid = 1'b0;
    logic [W-1:0]  pixel_color = '0;
    logic          pixel_sof = 1'b0;
    logic          pixel_ready;
    logic          frame_sync = 1'b0;
    logic          write_enable;
    logic [AL-1:0] write_addr;
    logic [W-1:0]  write_data;
    logic          swap_buffers;
    logic [15:0]   frame_count;
    logic          sof_error;

    frame_buffer_writer #(
        .WIDTH(W), .DISPLAY_WIDTH(DW), .DISPLAY_HEIGHT(DH), .ADDR_LEN(AL)
    ) dut (
        .clk(clk), .rst(rst),
        .pixel_valid(pixel_valid), .pixel_color(pixel_color), .pixel_sof(pixel_sof),
        .pixel_ready(pixel_ready), .frame_sync(frame_sync),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .swap_buffers(swap_buffers), .frame_count(frame_count), .sof_error(sof_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: position in frame, and whether the frame is writing, waiting for vblank, or swapping.
    bit   m_init  = 0;
    int   m_pos   = 0;
    int   m_phase = 0;
    bit   m_we    = 0;
    int   m_addr  = 0;
    int   m_data  = 0;
    bit   m_swap  = 0;
    int   m_fc    = 0;
    bit   m_sof   = 0;

    int log_addr[$];
    int log_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  p;
        bit  acc;
        p = m_phase;
        if (rst) begin
            m_init = 1; m_pos = 0; m_phase = 0; m_we = 0; m_addr = 0;
            m_data = 0; m_swap = 0; m_fc = 0; m_sof = 0;
        end else begin
            acc    = pixel_valid && (p == 0);
            m_we   = acc;
            m_swap = 0;
            if (acc) begin
                m_data = int'(pixel_color);
                if (pixel_sof && m_pos != 0) begin
                    m_sof  = 1;
                    m_addr = 0;
                    m_pos  = 1;
                end else begin
                    m_addr = m_pos;
                    m_pos  = m_pos + 1;
                    if (m_pos == DEPTH) begin
                        m_pos   = 0;
                        m_phase = 1;
                    end
                end
            end
            if (p == 1 && frame_sync) begin
                m_swap  = 1;
                m_fc    = m_fc + 1;
                m_phase = 2;
            end else if (p == 2) begin
                m_phase = 0;
            end
        end
    endtask

    task automatic compare_model();
        if (m_init) begin
            chk("cyc_pixel_ready",  32'(pixel_ready),  32'(m_phase == 0));
            chk("cyc_write_enable", 32'(write_enable), 32'(m_we));
            chk("cyc_write_addr",   32'(write_addr),   32'(m_addr));
            chk("cyc_write_data",   32'(write_data),   32'(m_data));
            chk("cyc_swap_buffers", 32'(swap_buffers), 32'(m_swap));
            chk("cyc_frame_count",  32'(frame_count),  32'(m_fc & 16'hFFFF));
            chk("cyc_sof_error",    32'(sof_error),    32'(m_sof));
            if (write_enable && swap_buffers)
                chk("cyc_we_swap_exclusive", 32'(1), 32'(0));
            if (write_enable) begin
                log_addr.push_back(int'(write_addr));
                log_data.push_back(int'(write_data));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic chk_log(input string name, input int idx, input int exp_addr, input int exp_data);
        if (idx >= log_addr.size()) begin
            chk({name, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
        end else begin
            chk({name, "_addr"}, 32'(log_addr[idx]), 32'(exp_addr));
            chk({name, "_data"}, 32'(log_data[idx]), 32'(exp_data));
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_we",    32'(write_enable), 32'(0));
        chk("rst_addr",  32'(write_addr),   32'(0));
        chk("rst_data",  32'(write_data),   32'(0));
        chk("rst_swap",  32'(swap_buffers), 32'(0));
        chk("rst_fc",    32'(frame_count),  32'(0));
        chk("rst_sof",   32'(sof_error),    32'(0));
        chk("rst_ready", 32'(pixel_ready),  32'(1));
        rst = 1'b0;
        tick();

        // Frame 1: continuous stream 0x100..0x107
        clear_log();
        for (int i = 0; i < 8; i++) begin
            pixel_valid = 1'b1; pixel_color = 12'h100 + 12'(i);
            tick();
            if (i == 0) chk("f1_first_we", 32'(write_enable), 32'(1));
        end
        pixel_valid = 1'b0;
        chk("f1_ready_low", 32'(pixel_ready), 32'(0));
        tick();
        chk("f1_log_size", 32'(log_addr.size()), 32'(8));
        for (int i = 0; i < 8; i++) chk_log("f1_w", i, i, 12'h100 + i);

        // frame_sync 5 cycles after the frame completes
        repeat (3) tick();
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("sw1_swap",  32'(swap_buffers), 32'(1));
        chk("sw1_we",    32'(write_enable), 32'(0));
        chk("sw1_fc",    32'(frame_count),  32'(1));
        chk("sw1_ready", 32'(pixel_ready),  32'(0));
        tick();
        chk("sw1_swap_gone", 32'(swap_buffers), 32'(0));
        chk("sw1_ready_back", 32'(pixel_ready), 32'(1));

        // Frame 2 with frame_sync coinciding with the final accept (must be ignored)
        clear_log();
        for (int i = 0; i < 8; i++) begin
            pixel_valid = 1'b1; pixel_color = 12'h200 + 12'(i);
            frame_sync  = (i == 7);
            tick();
        end
        pixel_valid = 1'b0; frame_sync = 1'b0;
        chk("f2_no_swap", 32'(swap_buffers), 32'(0));
        chk_log("f2_first", 0, 0, 12'h200);
        repeat (9) tick();
        chk("f2_no_swap_late", 32'(swap_buffers), 32'(0));
        chk("f2_fc_held", 32'(frame_count), 32'(1));
        frame_sync = 1'b1;
        tick();
        frame_sync = 1'b0;
        chk("sw2_swap", 32'(swap_buffers), 32'(1));
        chk("sw2_fc",   32'(frame_count),  32'(2));
        tick();

        // Frame 3: valid toggling, then misaligned SOF at addr 3
        clear_log();
        for (int i = 0; i < 6; i++) begin
            pixel_valid = ((i % 2) == 0); pixel_color = 12'h300 + 12'(i);
            tick();
            if (i == 1) chk("gap_we_low", 32'(write_enable), 32'(0));
            if (i == 1) chk("gap_data_hold", 32'(write_data), 32'(12'h300));
        end
        pixel_valid = 1'b1; pixel_color = 12'h3AA; pixel_sof = 1'b1;
        tick();
        pixel_sof = 1'b0;
        chk("sof_err_set", 32'(sof_error), 32'(1));
        chk("sof_resync_addr", 32'(write_addr), 32'(0));
        pixel_color = 12'h3B0; tick();
        pixel_color = 12'h3B1; tick();
        pixel_valid = 1'b0;
        tick();
        chk_log("tog0", 0, 0, 12'h300);
        chk_log("tog1", 1, 1, 12'h302);
        chk_log("tog2", 2, 2, 12'h304);
        chk_log("sof0", 3, 0, 12'h3AA);
        chk_log("sof1", 4, 1, 12'h3B0);
        chk_log("sof2", 5, 2, 12'h3B1);
        repeat (3) tick();
        chk("sof_err_sticky", 32'(sof_error), 32'(1));

        // Reset mid-frame: finish this frame, swap, then 5 accepts and reset
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1; pixel_color = 12'h400 + 12'(i); tick();
        end
        pixel_valid = 1'b0;
        frame_sync = 1'b1; tick(); frame_sync = 1'b0; tick();
        chk("pre_rst_fc", 32'(frame_count), 32'(3));
        for (int i = 0; i < 5; i++) begin
            pixel_valid = 1'b1; pixel_color = 12'h500 + 12'(i); tick();
        end
        pixel_valid = 1'b0; rst = 1'b1;
        tick();
        chk("mrst_we",    32'(write_enable), 32'(0));
        chk("mrst_addr",  32'(write_addr),   32'(0));
        chk("mrst_data",  32'(write_data),   32'(0));
        chk("mrst_fc",    32'(frame_count),  32'(0));
        chk("mrst_sof",   32'(sof_error),    32'(0));
        chk("mrst_ready", 32'(pixel_ready),  32'(1));
        rst = 1'b0;
        clear_log();
        pixel_valid = 1'b1; pixel_color = 12'h6C3; tick();
        pixel_valid = 1'b0; tick();
        chk_log("mrst_first", 0, 0, 12'h6C3);
        chk("mrst_fc_after", 32'(frame_count), 32'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Upstream stage of the double-buffered frame store.
- Accepts the renderer's row-major pixel stream on a valid/ready handshake and turns it into write_enable / write_addr / write_data for the double-buffer manager.
- Issues the one-cycle swap_buffers pulse only at a display frame_sync (vblank start), so the displayed buffer never tears.
- Throttles the renderer while a finished frame waits for the swap.

Parameters:
- WIDTH, `COLOR_BITS, pixel color width.
- DISPLAY_WIDTH, `DISPLAY_WIDTH, pixels per row.
- DISPLAY_HEIGHT, `DISPLAY_HEIGHT, rows per frame.
- ADDR_LEN, `ADDR_BITS, frame-buffer address width; must be at least clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- pixel_valid  input  1  renderer has a pixel on pixel_color.
- pixel_color  input  WIDTH  pixel value.
- pixel_sof  input  1  qualifies the first pixel of a frame (only meaningful with pixel_valid).
- pixel_ready  output  1  writer accepts a pixel this cycle.
- frame_sync  input  1  one-cycle pulse at display vblank start.
- write_enable  output  1  to manager write_enable.
- write_addr  output  ADDR_LEN  to manager write_addr.
- write_data  output  WIDTH  to manager write_data.
- swap_buffers  output  1  to manager swap_buffers; one-cycle pulse.
- frame_count  output  16  number of completed swaps, wraps modulo 2^16.
- sof_error  output  1  sticky; a misaligned pixel_sof was detected.

Behaviour:
- DEPTH = DISPLAY_WIDTH*DISPLAY_HEIGHT. Internal addr counter ranges 0..DEPTH-1.
- States: WRITING, FRAME_DONE, SWAP.
- Reset (synchronous): state=WRITING, addr=0, write_enable=0, write_addr=0, write_data=0, swap_buffers=0, frame_count=0, sof_error=0.
- The first frame after reset needs no swap. The manager already targets the non-displayed buffer.
- pixel_ready = (state==WRITING), combinational from state only. No dependence on pixel_valid.
- Handshake: a pixel is accepted when pixel_valid && pixel_ready.
- Write output timing: all write outputs are registered. On the cycle after an accept:
  - write_enable=1
  - write_addr = addr at the time of accept
  - write_data = the accepted pixel_color
- Write outputs otherwise: write_enable=0 on any cycle with no accept. write_addr and write_data hold their last values.
- Address advance: addr increments by 1 on each accept.
- End of frame: an accept at addr==DEPTH-1 sets addr to 0 and state to FRAME_DONE.
- SOF alignment:
  - If an accepted pixel has pixel_sof=1 and addr!=0: sof_error is set, and that pixel is written at address 0 (resync). addr becomes 1.
  - sof_error clears only on rst.
  - pixel_sof=0 at addr==0 is not an error.
- FRAME_DONE:
  - pixel_ready=0.
  - frame_sync is sampled only in this state.
  - On frame_sync=1, go to SWAP.
  - A frame_sync arriving on the same cycle as the final accept (state still WRITING) is ignored. The writer waits for the next pulse.
- SWAP (exactly one cycle):
  - swap_buffers=1, write_enable=0.
  - frame_count increments.
  - Next state is WRITING.
  - Pulse is registered: swap_buffers is high on the cycle after the frame_sync cycle.
- Ordering guarantee: the final pixel's write_enable always precedes swap_buffers by at least 1 cycle. swap_buffers and write_enable are never both high.
- Throughput: 1 pixel/cycle sustained in WRITING. Per-frame overhead is the frame_sync wait plus 1 SWAP cycle.
- Reset mid-frame: partial frame is abandoned; behaviour is as at reset. The downstream manager shares rst, so buffer selection re-aligns.

Test Plan:
(Bench parameters DISPLAY_WIDTH=4, DISPLAY_HEIGHT=2, WIDTH=12.)
- Reset, then continuous valid with colors 0x100..0x107 -> write_enable high on cycles 1..8 after first accept, write_addr 0..7, write_data 0x100..0x107; pixel_ready falls the cycle after the 8th accept.
- Frame complete, frame_sync pulsed 5 cycles later -> swap_buffers high exactly the next cycle with write_enable=0, frame_count=1, pixel_ready=1 the following cycle; next frame writes addr 0 again.
- frame_sync asserted on the same cycle as the 8th accept -> no swap; second frame_sync 10 cycles later -> swap_buffers 1 cycle after it.
- Valid toggled 1,0,1,0 with ready high -> write_enable mirrors accepts delayed by 1; addr advances only on accepts; write_data holds during gaps.
- pixel_sof=1 on the 4th accepted pixel (addr 3) -> sof_error=1 and stays 1; that pixel written at addr 0; next accepts at addr 1,2,…
- rst asserted after 5 accepts -> next cycle all outputs 0, pixel_ready=1; subsequent first accept writes addr 0, frame_count=0.
